// File: rtl/seven_seg_counter_sys_mem_arb_pkg.sv
// Shared types and default geometry for the two-master on-chip RAM arbiter.
package seven_seg_counter_sys_mem_arb_pkg;

  localparam int ARB_ADDR_W    = 14;
  localparam int ARB_DATA_W    = 32;
  localparam int ARB_BE_W      = ARB_DATA_W / 8;
  localparam int ARB_DEPTH     = 10000;
  localparam int ARB_MAX_BURST = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_t;

  // One-hot grant to owner index; an empty grant maps to m0.
  function automatic owner_t owner_of(input logic [1:0] grant);
    if (grant[1]) begin
      return OWNER_M1;
    end else begin
      return OWNER_M0;
    end
  endfunction

endpackage

// File: rtl/seven_seg_counter_sys_onchip_mem_arbiter_if.sv
// Avalon-MM bundle for one master port of the on-chip RAM arbiter.
interface seven_seg_counter_sys_onchip_mem_arbiter_if #(
  parameter int ADDR_W = seven_seg_counter_sys_mem_arb_pkg::ARB_ADDR_W,
  parameter int DATA_W = seven_seg_counter_sys_mem_arb_pkg::ARB_DATA_W,
  parameter int BE_W   = seven_seg_counter_sys_mem_arb_pkg::ARB_BE_W
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/seven_seg_counter_sys_mem_arb_rr.sv
// Round-robin grant/yield FSM with bounded burst hold for two masters.
module seven_seg_counter_sys_mem_arb_rr
  import seven_seg_counter_sys_mem_arb_pkg::*;
#(
  parameter int MAX_BURST = ARB_MAX_BURST
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output owner_t     owner
);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_t       state_r;
  owner_t           last_r;
  owner_t           owner_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] eff_cnt_s;
  logic             other_req_s;

  // Grant decode: owner keeps the bus while requesting, else the other master takes it at once.
  always_comb begin
    grant = 2'b00;
    if (reset) begin
      grant = 2'b00;
    end else begin
      case (state_r)
        OWN0: begin
          if (req[0]) grant = 2'b01;
          else if (req[1]) grant = 2'b10;
          else grant = 2'b00;
        end
        OWN1: begin
          if (req[1]) grant = 2'b10;
          else if (req[0]) grant = 2'b01;
          else grant = 2'b00;
        end
        default: begin
          if (req == 2'b11) grant = (last_r == OWNER_M1) ? 2'b01 : 2'b10;
          else grant = req;
        end
      endcase
    end
  end

  // Burst position of this accept; a grant to a non-owner starts a fresh burst.
  always_comb begin
    eff_cnt_s   = {CNT_W{1'b0}};
    other_req_s = grant[1] ? req[0] : req[1];
    if ((state_r == OWN0 && grant[0]) || (state_r == OWN1 && grant[1])) begin
      eff_cnt_s = cnt_r;
    end else begin
      eff_cnt_s = {CNT_W{1'b0}};
    end
  end

  // Ownership FSM, burst counter and last-granted record.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      last_r  <= OWNER_M1;
      owner_r <= OWNER_M0;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (grant != 2'b00) begin
      last_r <= owner_of(grant);
      if (other_req_s && (eff_cnt_s == CNT_W'(MAX_BURST - 1))) begin
        state_r <= grant[1] ? OWN0 : OWN1;
        owner_r <= grant[1] ? OWNER_M0 : OWNER_M1;
        cnt_r   <= {CNT_W{1'b0}};
      end else begin
        state_r <= grant[1] ? OWN1 : OWN0;
        owner_r <= owner_of(grant);
        cnt_r   <= (eff_cnt_s == CNT_W'(MAX_BURST - 1)) ? eff_cnt_s : eff_cnt_s + CNT_W'(1);
      end
    end else begin
      state_r <= IDLE;
      owner_r <= owner_r;
      cnt_r   <= {CNT_W{1'b0}};
    end
  end

  assign owner = owner_r;

endmodule

// File: rtl/seven_seg_counter_sys_onchip_mem_arbiter.sv
// Shares the single-port on-chip RAM between two Avalon-MM masters; traps out-of-range accesses.
module seven_seg_counter_sys_onchip_mem_arbiter
  import seven_seg_counter_sys_mem_arb_pkg::*;
#(
  parameter int ADDR_W    = ARB_ADDR_W,
  parameter int DATA_W    = ARB_DATA_W,
  parameter int BE_W      = ARB_BE_W,
  parameter int DEPTH     = ARB_DEPTH,
  parameter int MAX_BURST = ARB_MAX_BURST
) (
  input  logic                clk,
  input  logic                reset,
  seven_seg_counter_sys_onchip_mem_arbiter_if.slave m0,
  seven_seg_counter_sys_onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic [BE_W-1:0]     ram_byteenable,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic                err_oor,
  input  logic                err_clr
);
  logic [1:0]        req_s;
  logic [1:0]        grant_s;
  owner_t            owner_s;
  owner_t            sel_s;
  logic [ADDR_W-1:0] addr_s;
  logic              wr_s;
  logic [DATA_W-1:0] wdata_s;
  logic [BE_W-1:0]   be_s;
  logic              acc_s;
  logic              oor_s;
  logic [DATA_W-1:0] rdata_s;
  logic              rvalid0_s;
  logic              rvalid1_s;

  logic              rd_vld_r;
  owner_t            rd_tag_r;
  logic              rd_oor_r;
  logic [DATA_W-1:0] hold0_r;
  logic [DATA_W-1:0] hold1_r;
  logic              err_oor_r;

  // Request vector from the command strobes.
  always_comb begin
    req_s = {m1.read | m1.write, m0.read | m0.write};
  end

  seven_seg_counter_sys_mem_arb_rr #(
    .MAX_BURST (MAX_BURST)
  ) u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (req_s),
    .grant (grant_s),
    .owner (owner_s)
  );

  // Command mux; with no grant the bus parks on the current owner's command.
  always_comb begin
    sel_s   = owner_s;
    addr_s  = m0.address;
    wr_s    = m0.write;
    wdata_s = m0.writedata;
    be_s    = m0.byteenable;
    if (grant_s != 2'b00) sel_s = owner_of(grant_s);
    else sel_s = owner_s;
    if (sel_s == OWNER_M1) begin
      addr_s  = m1.address;
      wr_s    = m1.write;
      wdata_s = m1.writedata;
      be_s    = m1.byteenable;
    end else begin
      addr_s  = m0.address;
      wr_s    = m0.write;
      wdata_s = m0.writedata;
      be_s    = m0.byteenable;
    end
  end

  // RAM drive and waitrequest; out-of-range commands are accepted but never reach the RAM.
  always_comb begin
    acc_s          = (grant_s != 2'b00);
    oor_s          = (addr_s >= ADDR_W'(DEPTH));
    ram_address    = addr_s;
    ram_writedata  = wdata_s;
    ram_byteenable = be_s;
    ram_chipselect = acc_s & ~oor_s;
    ram_write      = acc_s & wr_s & ~oor_s;
    ram_clken      = ~reset;
    m0.waitrequest = ~grant_s[0];
    m1.waitrequest = ~grant_s[1];
  end

  // Read return steering; the non-returning master keeps its last data.
  always_comb begin
    rdata_s   = rd_oor_r ? {DATA_W{1'b0}} : ram_readdata;
    rvalid0_s = rd_vld_r & (rd_tag_r == OWNER_M0) & ~reset;
    rvalid1_s = rd_vld_r & (rd_tag_r == OWNER_M1) & ~reset;
    m0.readdatavalid = rvalid0_s;
    m1.readdatavalid = rvalid1_s;
    m0.readdata      = rvalid0_s ? rdata_s : hold0_r;
    m1.readdata      = rvalid1_s ? rdata_s : hold1_r;
    err_oor          = err_oor_r;
  end

  // Read tag, held read data and sticky out-of-range flag (a new trap beats err_clr).
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_r  <= 1'b0;
      rd_tag_r  <= OWNER_M0;
      rd_oor_r  <= 1'b0;
      hold0_r   <= {DATA_W{1'b0}};
      hold1_r   <= {DATA_W{1'b0}};
      err_oor_r <= 1'b0;
    end else begin
      rd_vld_r <= acc_s & ~wr_s;
      rd_tag_r <= sel_s;
      rd_oor_r <= oor_s;
      if (rvalid0_s) hold0_r <= rdata_s;
      else hold0_r <= hold0_r;
      if (rvalid1_s) hold1_r <= rdata_s;
      else hold1_r <= hold1_r;
      if (acc_s && oor_s) err_oor_r <= 1'b1;
      else if (err_clr) err_oor_r <= 1'b0;
      else err_oor_r <= err_oor_r;
    end
  end

endmodule

// File: tb/tb_seven_seg_counter_sys_onchip_mem_arbiter.sv
// Scoreboard bench for the two-master on-chip RAM arbiter with a behavioural RAM model.
module tb_seven_seg_counter_sys_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        err_clr;
  logic        err_oor;
  logic [13:0] ram_address;
  logic        ram_chipselect;
  logic        ram_write;
  logic        ram_clken;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;
  logic [3:0]  ram_byteenable;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] hold_exp [2];

  logic [31:0] mem [0:9999];
  logic [13:0] raddr_q;
  logic        mem_clr;

  int cont_g [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  bit sw_r0  [9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  bit sw_r1  [9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  int sw_g   [9]  = '{2, 0, 0, 1, 1, 1, 1, 0, 2};

  seven_seg_counter_sys_onchip_mem_arbiter_if m0_if ();
  seven_seg_counter_sys_onchip_mem_arbiter_if m1_if ();

  seven_seg_counter_sys_onchip_mem_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .m0             (m0_if),
    .m1             (m1_if),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_writedata  (ram_writedata),
    .ram_byteenable (ram_byteenable),
    .ram_clken      (ram_clken),
    .ram_readdata   (ram_readdata),
    .err_oor        (err_oor),
    .err_clr        (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered address, unregistered q, byte-lane writes.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 10000; i++) mem[i] <= 32'h0;
      raddr_q <= 14'd0;
    end else if (ram_clken && ram_chipselect) begin
      if (ram_write)
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      raddr_q <= ram_address;
    end
  end

  assign ram_readdata = mem[raddr_q];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input int m, input bit rd, input bit wr, input logic [13:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (m == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
      m0_if.writedata = d; m0_if.byteenable = be;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
      m1_if.writedata = d; m1_if.byteenable = be;
    end
  endtask

  function automatic logic wreq(input int m);
    if (m == 0) return m0_if.waitrequest;
    else return m1_if.waitrequest;
  endfunction

  task automatic push(input int m, input logic [31:0] d);
    exp_t e;
    e.data = d;
    e.due  = cyc + 1;
    if (m == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // One command from master m, waiting a bounded time for acceptance.
  task automatic xfer(input int m, input bit wr, input logic [13:0] a, input logic [31:0] d,
                      input logic [3:0] be, input bit cs_exp, input bit push_rd,
                      input logic [31:0] exp_d);
    drive(m, !wr, wr, a, d, be);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (!wreq(m)) break;
      @(posedge clk); #1;
    end
    chk($sformatf("accept_m%0d", m), {31'd0, wreq(m)}, 32'd0);
    if (!wreq(m)) begin
      chk($sformatf("ram_cs_m%0d", m), {31'd0, ram_chipselect}, {31'd0, cs_exp});
      chk($sformatf("ram_wr_m%0d", m), {31'd0, ram_write}, {31'd0, wr & cs_exp});
      if (cs_exp) chk($sformatf("ram_addr_m%0d", m), {18'd0, ram_address}, {18'd0, a});
      if (push_rd) push(m, exp_d);
    end
    @(posedge clk); #1;
    drive(m, 1'b0, 1'b0, a, d, be);
  endtask

  // One cycle of a contention table: m0 reads 20, m1 reads 30; g = expected winner (2 = none).
  task automatic run_row(input string tag, input int row, input bit r0, input bit r1, input int g);
    logic [1:0] w_exp;
    drive(0, r0, 1'b0, 14'd20, 32'h0, 4'h0);
    drive(1, r1, 1'b0, 14'd30, 32'h0, 4'h0);
    @(negedge clk);
    w_exp = (g == 0) ? 2'b10 : ((g == 1) ? 2'b01 : 2'b11);
    chk($sformatf("grant_%s_row%0d", tag, row),
        {30'd0, m1_if.waitrequest, m0_if.waitrequest}, {30'd0, w_exp});
    if (!m0_if.waitrequest) push(0, 32'hA0A0_0020);
    if (!m1_if.waitrequest) push(1, 32'hB1B1_0030);
    @(posedge clk); #1;
  endtask

  task automatic mon(input int m, input logic v, input logic [31:0] d, input logic [31:0] od);
    exp_t e;
    if (v) begin
      if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
        n_tests++;
        n_fail++;
        $display("FAIL rdv_unexpected_m%0d: actual valid with data %h required no valid", m, d);
      end else begin
        if (m == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk($sformatf("rdata_m%0d", m), d, e.data);
        chk($sformatf("rd_latency_m%0d", m), cyc, e.due);
        chk($sformatf("hold_m%0d", 1 - m), od, hold_exp[1 - m]);
        hold_exp[m] = e.data;
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever a master sees readdatavalid.
  always @(negedge clk) begin
    if (reset) begin
      hold_exp[0] = 32'h0;
      hold_exp[1] = 32'h0;
      if (m0_if.readdatavalid || m1_if.readdatavalid) begin
        n_tests++;
        n_fail++;
        $display("FAIL rdv_in_reset: actual %b%b required 00",
                 m1_if.readdatavalid, m0_if.readdatavalid);
      end
    end else begin
      mon(0, m0_if.readdatavalid, m0_if.readdata, m1_if.readdata);
      mon(1, m1_if.readdatavalid, m1_if.readdata, m0_if.readdata);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    err_clr = 1'b0;
    mem_clr = 1'b1;
    drive(0, 1'b1, 1'b0, 14'd5, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 14'd0, 32'h0, 4'h0);
    @(posedge clk); #1;
    mem_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_wait_m0", {31'd0, m0_if.waitrequest}, 32'd1);
    chk("rst_wait_m1", {31'd0, m1_if.waitrequest}, 32'd1);
    chk("rst_rdata_m0", m0_if.readdata, 32'h0);
    chk("rst_cs", {31'd0, ram_chipselect}, 32'd0);
    chk("rst_clken", {31'd0, ram_clken}, 32'd0);
    chk("rst_err", {31'd0, err_oor}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 14'd0, 32'h0, 4'h0);
    @(negedge clk);
    chk("clken_run", {31'd0, ram_clken}, 32'd1);
    @(posedge clk); #1;

    // Sole master write/read and byte lanes.
    xfer(0, 1'b1, 14'd5, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 32'h0);
    xfer(0, 1'b0, 14'd5, 32'h0, 4'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    xfer(0, 1'b1, 14'd7, 32'h1122_3344, 4'b0101, 1'b1, 1'b0, 32'h0);
    xfer(0, 1'b0, 14'd7, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0022_0044);
    xfer(0, 1'b1, 14'd20, 32'hA0A0_0020, 4'hF, 1'b1, 1'b0, 32'h0);
    xfer(1, 1'b1, 14'd30, 32'hB1B1_0030, 4'hF, 1'b1, 1'b0, 32'h0);

    // Contention from reset, then owner drop with zero bubble.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) run_row("cont", i, 1'b1, 1'b1, cont_g[i]);
    for (int i = 0; i < 9; i++) run_row("switch", i, sw_r0[i], sw_r1[i], sw_g[i]);

    // Out-of-range read, err_clr, and a trap coinciding with err_clr.
    xfer(1, 1'b0, 14'd10000, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    chk("err_set", {31'd0, err_oor}, 32'd1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_clr", {31'd0, err_oor}, 32'd0);
    @(posedge clk); #1;
    err_clr = 1'b1;
    xfer(0, 1'b1, 14'h3FFF, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 32'h0);
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_set_wins", {31'd0, err_oor}, 32'd1);
    @(posedge clk); #1;

    // Reset in the cycle after a read accept.
    xfer(0, 1'b0, 14'd5, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    reset = 1'b1;
    drive(0, 1'b1, 1'b0, 14'd5, 32'h0, 4'h0);
    @(negedge clk);
    chk("rdv_after_reset_m0", {31'd0, m0_if.readdatavalid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst2_wait_m0", {31'd0, m0_if.waitrequest}, 32'd1);
    chk("rst2_rdata_m0", m0_if.readdata, 32'h0);
    chk("rst2_rdata_m1", m1_if.readdata, 32'h0);
    chk("rst2_cs", {31'd0, ram_chipselect}, 32'd0);
    chk("rst2_wr", {31'd0, ram_write}, 32'd0);
    chk("rst2_clken", {31'd0, ram_clken}, 32'd0);
    chk("rst2_err", {31'd0, err_oor}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 14'd0, 32'h0, 4'h0);
    xfer(0, 1'b0, 14'd5, 32'h0, 4'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drain_m0", q0.size(), 32'd0);
    chk("drain_m1", q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
